// File: rtl/bus_pkg.sv
// Shared types and defaults for the register-bus transfer sequencer.
package bus_pkg;

    localparam int unsigned NUM_REGS_DEFAULT = 8;
    localparam int unsigned MAX_SEL_W        = 8;

    typedef enum logic [1:0] {
        StIdle,
        StSettle,
        StLatch,
        StRelease
    } state_e;

    typedef struct packed {
        logic [MAX_SEL_W-1:0] src;
        logic [MAX_SEL_W-1:0] dst;
    } req_t;

endpackage

// File: rtl/bus_transfer_sequencer_if.sv
// Request port and bus strobe bundle between the sequencer and its environment.
interface bus_transfer_sequencer_if
    import bus_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS),
    parameter int unsigned DEPTH    = 4
) ();

    logic                     req_valid;
    logic                     req_ready;
    logic [SEL_W-1:0]         req_src;
    logic [SEL_W-1:0]         req_dst;
    logic [NUM_REGS-1:0]      bus_out_en;
    logic [NUM_REGS-1:0]      bus_in_en;
    logic                     busy;
    logic                     done_pulse;
    logic                     err_pulse;
    logic [$clog2(DEPTH):0]   queue_count;

    // Sequencer side.
    modport master (
        input  req_valid, req_src, req_dst,
        output req_ready, bus_out_en, bus_in_en, busy, done_pulse, err_pulse, queue_count
    );

    // Requester / register-block side.
    modport slave (
        output req_valid, req_src, req_dst,
        input  req_ready, bus_out_en, bus_in_en, busy, done_pulse, err_pulse, queue_count
    );

endinterface

// File: rtl/seq_req_fifo.sv
// Synchronous request FIFO with occupancy count; pointers wrap modulo DEPTH.
module seq_req_fifo
    import bus_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   register_clock,
    input  logic                   register_reset,
    input  logic                   i_push,
    input  req_t                   i_data,
    input  logic                   i_pop,
    output req_t                   o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_empty,
    output logic                   o_full
);

    localparam int unsigned         PtrW    = $clog2(DEPTH);
    localparam int unsigned         CntW    = PtrW + 1;
    localparam logic [CntW-1:0]     FullCnt = DEPTH[CntW-1:0];

    req_t            r_mem [DEPTH];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == FullCnt);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    always_ff @(posedge register_clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge register_clock) begin
        if (register_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PtrW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            unique case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/bus_transfer_sequencer.sv
// Bus initiator: queues src->dst register transfers and strobes one-hot drive/latch enables.
module bus_transfer_sequencer
    import bus_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS),
    parameter int unsigned DEPTH    = 4
) (
    input  logic                     register_clock,
    input  logic                     register_reset,
    bus_transfer_sequencer_if.master io_bus
);

    localparam int unsigned      CntW     = $clog2(DEPTH) + 1;
    localparam logic [SEL_W:0]   NumRegsL = NUM_REGS[SEL_W:0];

    state_e              r_state;
    state_e              w_state_d;
    req_t                r_cur;
    req_t                w_head;
    req_t                w_req_in;
    logic                w_handshake;
    logic                w_invalid;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_full;
    logic [CntW-1:0]     w_count;
    logic [NUM_REGS-1:0] r_out_en;
    logic [NUM_REGS-1:0] r_in_en;
    logic [NUM_REGS-1:0] w_out_en_d;
    logic [NUM_REGS-1:0] w_in_en_d;
    logic                r_done;
    logic                r_err;

    // Ready depends only on occupancy; validation happens after the handshake.
    assign w_handshake = io_bus.req_valid && !w_full;
    assign w_invalid   = (io_bus.req_src == io_bus.req_dst)
                      || ({1'b0, io_bus.req_src} >= NumRegsL)
                      || ({1'b0, io_bus.req_dst} >= NumRegsL);
    assign w_push      = w_handshake && !w_invalid;
    assign w_pop       = !w_empty && ((r_state == StIdle) || (r_state == StRelease));

    assign w_req_in.src = MAX_SEL_W'(io_bus.req_src);
    assign w_req_in.dst = MAX_SEL_W'(io_bus.req_dst);

    seq_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .register_clock (register_clock),
        .register_reset (register_reset),
        .i_push         (w_push),
        .i_data         (w_req_in),
        .i_pop          (w_pop),
        .o_data         (w_head),
        .o_count        (w_count),
        .o_empty        (w_empty),
        .o_full         (w_full)
    );

    always_ff @(posedge register_clock) begin
        if (register_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    w_state_d = w_empty ? StIdle : StSettle;
            StSettle:  w_state_d = StLatch;
            StLatch:   w_state_d = StRelease;
            StRelease: w_state_d = w_empty ? StIdle : StSettle;
            default:   w_state_d = StIdle;
        endcase
    end

    // Enables are decoded from the next state so the registered strobes line up with it.
    always_comb begin
        w_out_en_d = '0;
        w_in_en_d  = '0;
        case (w_state_d)
            StSettle: w_out_en_d = NUM_REGS'(1) << w_head.src;
            StLatch: begin
                w_out_en_d = NUM_REGS'(1) << r_cur.src;
                w_in_en_d  = NUM_REGS'(1) << r_cur.dst;
            end
            default: ;
        endcase
    end

    always_ff @(posedge register_clock) begin
        if (register_reset) begin
            r_out_en <= '0;
            r_in_en  <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cur    <= '0;
        end else begin
            r_out_en <= w_out_en_d;
            r_in_en  <= w_in_en_d;
            r_done   <= (w_state_d == StRelease);
            r_err    <= w_handshake && w_invalid;
            if (w_pop) begin
                r_cur <= w_head;
            end
        end
    end

    assign io_bus.req_ready   = !w_full;
    assign io_bus.bus_out_en  = r_out_en;
    assign io_bus.bus_in_en   = r_in_en;
    assign io_bus.busy        = (r_state != StIdle) || !w_empty;
    assign io_bus.done_pulse  = r_done;
    assign io_bus.err_pulse   = r_err;
    assign io_bus.queue_count = w_count;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Randomized and directed bench for bus_transfer_sequencer against a transfer-schedule model.
module tb_bus_transfer_sequencer;

    localparam int NR = 8;
    localparam int SW = 4;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_transfer_sequencer_if #(.NUM_REGS(NR), .SEL_W(SW), .DEPTH(DP)) bus_i ();

    bus_transfer_sequencer #(
        .NUM_REGS (NR),
        .SEL_W    (SW),
        .DEPTH    (DP)
    ) dut (
        .register_clock (clk),
        .register_reset (rst),
        .io_bus         (bus_i)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Model: every accepted good request gets a pop edge; its transfer occupies
    // the three cycles following that edge (drive, drive+latch, release).
    int pop_q[$];
    int src_q[$];
    int dst_q[$];
    int last_pop = -100;
    int err_e    = -100;

    logic [NR-1:0] prev_out = '0;
    logic [NR-1:0] m_out;
    logic [NR-1:0] m_in;
    logic          m_done;
    logic          m_busy;
    int            m_cnt;
    int            m_d;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, exp);
        end
    endtask

    function automatic int model_count(input int e);
        int n = 0;
        foreach (pop_q[k]) if (pop_q[k] > e) n++;
        return n;
    endfunction

    function automatic bit rejected(input int s, input int d);
        return (s == d) || (s >= NR) || (d >= NR);
    endfunction

    task automatic tick(output bit hs);
        bit take;
        int s;
        int d;
        int p;
        s    = int'(bus_i.req_src);
        d    = int'(bus_i.req_dst);
        take = !rst && bus_i.req_valid && (model_count(cyc) < DP);
        @(posedge clk);
        cyc++;
        if (rst) begin
            pop_q.delete();
            src_q.delete();
            dst_q.delete();
            last_pop = -100;
            err_e    = -100;
        end else if (take) begin
            if (rejected(s, d)) begin
                err_e = cyc;
            end else begin
                p = (cyc + 1 > last_pop + 3) ? cyc + 1 : last_pop + 3;
                pop_q.push_back(p);
                src_q.push_back(s);
                dst_q.push_back(d);
                last_pop = p;
            end
        end
        hs = take;
        @(negedge clk);
    endtask

    task automatic send(input int s, input int d);
        bit hs;
        bus_i.req_valid = 1'b1;
        bus_i.req_src   = SW'(s);
        bus_i.req_dst   = SW'(d);
        tick(hs);
        bus_i.req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit hs;
        for (int i = 0; i < n; i++) tick(hs);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            m_out  = '0;
            m_in   = '0;
            m_done = 1'b0;
            m_cnt  = model_count(cyc);
            m_busy = (m_cnt > 0);
            foreach (pop_q[k]) begin
                m_d = cyc - pop_q[k];
                if (m_d == 0) begin
                    m_out  = NR'(1) << src_q[k];
                    m_busy = 1'b1;
                end else if (m_d == 1) begin
                    m_out  = NR'(1) << src_q[k];
                    m_in   = NR'(1) << dst_q[k];
                    m_busy = 1'b1;
                end else if (m_d == 2) begin
                    m_done = 1'b1;
                    m_busy = 1'b1;
                end
            end
            chk("bus_out_en", 32'(bus_i.bus_out_en), 32'(m_out));
            chk("bus_in_en", 32'(bus_i.bus_in_en), 32'(m_in));
            chk("done_pulse", 32'(bus_i.done_pulse), 32'(m_done));
            chk("err_pulse", 32'(bus_i.err_pulse), 32'(err_e == cyc));
            chk("busy", 32'(bus_i.busy), 32'(m_busy));
            chk("queue_count", 32'(bus_i.queue_count), 32'(m_cnt));
            chk("req_ready", 32'(bus_i.req_ready), 32'(m_cnt < DP));
            chk("onehot_out", 32'($countones(bus_i.bus_out_en) <= 1), 32'd1);
            chk("onehot_in", 32'($countones(bus_i.bus_in_en) <= 1), 32'd1);
            chk("in_needs_out", 32'((bus_i.bus_in_en == '0) || (bus_i.bus_out_en != '0)), 32'd1);
            if (prev_out != '0 && bus_i.bus_out_en != '0) begin
                chk("dead_cycle", 32'(bus_i.bus_out_en), 32'(prev_out));
            end
            prev_out = bus_i.bus_out_en;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        bit            hs;
        bit            rdy;
        bit            saw_full;
        int            n_done;
        int            n_err;
        int            waited;
        int            bb_src[3] = '{1, 3, 0};
        int            bb_dst[3] = '{3, 0, 7};
        logic [NR-1:0] cap_out[10];
        logic [NR-1:0] cap_in[10];
        logic          cap_done[10];

        bus_i.req_valid = 1'b0;
        bus_i.req_src   = '0;
        bus_i.req_dst   = '0;
        rst = 1'b1;
        idle(2);
        chk("rst_out", 32'(bus_i.bus_out_en), 32'd0);
        chk("rst_in", 32'(bus_i.bus_in_en), 32'd0);
        chk("rst_busy", 32'(bus_i.busy), 32'd0);
        chk("rst_cnt", 32'(bus_i.queue_count), 32'd0);
        chk("rst_ready", 32'(bus_i.req_ready), 32'd1);
        chk("rst_done", 32'(bus_i.done_pulse), 32'd0);
        chk("rst_err", 32'(bus_i.err_pulse), 32'd0);
        rst    = 1'b0;
        chk_en = 1'b1;
        idle(1);

        // Single transfer 2 -> 5.
        send(2, 5);
        chk("single_cnt", 32'(bus_i.queue_count), 32'd1);
        idle(1);
        chk("single_settle_out", 32'(bus_i.bus_out_en), 32'h04);
        chk("single_settle_in", 32'(bus_i.bus_in_en), 32'h00);
        idle(1);
        chk("single_latch_out", 32'(bus_i.bus_out_en), 32'h04);
        chk("single_latch_in", 32'(bus_i.bus_in_en), 32'h20);
        idle(1);
        chk("single_rel_out", 32'(bus_i.bus_out_en), 32'h00);
        chk("single_rel_done", 32'(bus_i.done_pulse), 32'd1);
        idle(1);
        chk("single_busy_after", 32'(bus_i.busy), 32'd0);
        idle(2);

        // Back-to-back: three pushes on consecutive edges.
        for (int i = 0; i < 10; i++) begin
            if (i < 3) begin
                bus_i.req_valid = 1'b1;
                bus_i.req_src   = SW'(bb_src[i]);
                bus_i.req_dst   = SW'(bb_dst[i]);
            end else begin
                bus_i.req_valid = 1'b0;
            end
            tick(hs);
            cap_out[i]  = bus_i.bus_out_en;
            cap_in[i]   = bus_i.bus_in_en;
            cap_done[i] = bus_i.done_pulse;
        end
        chk("b2b_latch0", {16'd0, cap_out[2], cap_in[2]}, 32'h0208);
        chk("b2b_latch1", {16'd0, cap_out[5], cap_in[5]}, 32'h0801);
        chk("b2b_latch2", {16'd0, cap_out[8], cap_in[8]}, 32'h0180);
        chk("b2b_done", {29'd0, cap_done[3], cap_done[6], cap_done[9]}, 32'h7);
        chk("b2b_done_only3", 32'($countones({cap_done[0], cap_done[1], cap_done[2], cap_done[4],
                                              cap_done[5], cap_done[7], cap_done[8]})), 32'd0);
        chk("b2b_rel_zero", {8'd0, cap_out[3] | cap_in[3], cap_out[6] | cap_in[6],
                             cap_out[9] | cap_in[9]}, 32'd0);
        idle(2);

        // Full FIFO: seven requests with valid held until the DUT takes each.
        saw_full = 1'b0;
        n_done   = 0;
        n_err    = 0;
        for (int r = 0; r < 7; r++) begin
            bus_i.req_valid = 1'b1;
            bus_i.req_src   = SW'(r);
            bus_i.req_dst   = SW'((r + 1) % NR);
            waited = 0;
            do begin
                rdy = bus_i.req_ready;
                tick(hs);
                waited++;
                if (!bus_i.req_ready && bus_i.queue_count == 4) saw_full = 1'b1;
                n_done += int'(bus_i.done_pulse);
                n_err  += int'(bus_i.err_pulse);
            end while (!rdy && waited < 20);
            chk("full_hold_bound", 32'(rdy), 32'd1);
        end
        bus_i.req_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick(hs);
            n_done += int'(bus_i.done_pulse);
            n_err  += int'(bus_i.err_pulse);
        end
        chk("full_seen", 32'(saw_full), 32'd1);
        chk("full_done_count", n_done, 32'd7);
        chk("full_no_err", n_err, 32'd0);

        // Rejection.
        send(4, 4);
        chk("rej_same_err", 32'(bus_i.err_pulse), 32'd1);
        chk("rej_same_cnt", 32'(bus_i.queue_count), 32'd0);
        send(9, 1);
        chk("rej_range_err", 32'(bus_i.err_pulse), 32'd1);
        chk("rej_range_cnt", 32'(bus_i.queue_count), 32'd0);
        idle(1);
        chk("rej_err_clear", 32'(bus_i.err_pulse), 32'd0);
        chk("rej_no_en", 32'(bus_i.bus_out_en), 32'd0);
        idle(2);

        // Reset during LATCH with two entries queued.
        bus_i.req_valid = 1'b1;
        bus_i.req_src = SW'(5); bus_i.req_dst = SW'(6); tick(hs);
        bus_i.req_src = SW'(6); bus_i.req_dst = SW'(7); tick(hs);
        bus_i.req_src = SW'(7); bus_i.req_dst = SW'(0); tick(hs);
        bus_i.req_valid = 1'b0;
        chk("mid_latch_in", 32'(bus_i.bus_in_en), 32'h40);
        chk("mid_cnt", 32'(bus_i.queue_count), 32'd2);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        chk("mid_rst_out", 32'(bus_i.bus_out_en), 32'd0);
        chk("mid_rst_in", 32'(bus_i.bus_in_en), 32'd0);
        chk("mid_rst_cnt", 32'(bus_i.queue_count), 32'd0);
        chk("mid_rst_busy", 32'(bus_i.busy), 32'd0);
        chk("mid_rst_done", 32'(bus_i.done_pulse), 32'd0);
        idle(1);
        chk("mid_rst_done2", 32'(bus_i.done_pulse), 32'd0);
        idle(1);

        // Push on the same edge the FSM pops the only entry.
        send(3, 4);
        send(6, 2);
        chk("pp_cnt", 32'(bus_i.queue_count), 32'd1);
        chk("pp_settle_a", 32'(bus_i.bus_out_en), 32'h08);
        idle(3);
        chk("pp_settle_b", 32'(bus_i.bus_out_en), 32'h40);
        idle(1);
        chk("pp_latch_b", {16'd0, bus_i.bus_out_en, bus_i.bus_in_en}, 32'h4004);
        idle(3);

        // Random traffic with occasional resets.
        for (int i = 0; i < 500; i++) begin
            rst             = ($urandom_range(0, 79) == 0);
            bus_i.req_valid = ($urandom_range(0, 9) < 7);
            bus_i.req_src   = SW'($urandom_range(0, 9));
            bus_i.req_dst   = SW'($urandom_range(0, 9));
            tick(hs);
        end
        rst             = 1'b0;
        bus_i.req_valid = 1'b0;
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
